// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation encodings, bit positions and WARL masks
// for the machine-mode CSR file.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS        = 12'h300;
    localparam logic [11:0] CSR_MISA           = 12'h301;
    localparam logic [11:0] CSR_MIE            = 12'h304;
    localparam logic [11:0] CSR_MTVEC          = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3     = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT31    = 12'h33F;
    localparam logic [11:0] CSR_MSCRATCH       = 12'h340;
    localparam logic [11:0] CSR_MEPC           = 12'h341;
    localparam logic [11:0] CSR_MCAUSE         = 12'h342;
    localparam logic [11:0] CSR_MTVAL          = 12'h343;
    localparam logic [11:0] CSR_MIP            = 12'h344;
    localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3   = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER31  = 12'hB1F;
    localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H  = 12'hB83;
    localparam logic [11:0] CSR_MHPMCOUNTER31H = 12'hB9F;
    localparam logic [11:0] CSR_MVENDORID      = 12'hF11;
    localparam logic [11:0] CSR_MARCHID        = 12'hF12;
    localparam logic [11:0] CSR_MIMPID         = 12'hF13;
    localparam logic [11:0] CSR_MHARTID        = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_MSIP_BIT     = 3;
    localparam int unsigned MIP_MTIP_BIT     = 7;
    localparam int unsigned MIP_MEIP_BIT     = 11;

    localparam logic [31:0] MSTATUS_MPP_FIXED = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK         = 32'h0000_0888;
    localparam logic [31:0] MEPC_WMASK        = 32'hFFFF_FFFC;
    localparam logic [31:0] MISA_VALUE        = 32'h4000_0100;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        case (op)
            CSR_OP_RW: return wdata;
            CSR_OP_RS: return old_val | wdata;
            CSR_OP_RC: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with increment enable and independent lo/hi half writes.
// A half write takes priority and suppresses that cycle's increment.
module csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_we_lo) begin
            cnt_d[31:0] = i_wdata;
        end else if (i_we_hi) begin
            cnt_d[63:32] = i_wdata;
        end else if (i_inc) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_value = cnt_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRW/RS/RC access with legality checks, 64-bit
// counters with inhibit, trap entry and mret handling.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter int unsigned      HPM_COUNTERS = 4,
    parameter logic [XLEN-1:0]  MHARTID      = '0,
    parameter logic [XLEN-1:0]  RESET_MTVEC  = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_csr_valid,
    input  logic [1:0]              i_csr_op,
    input  logic [11:0]             i_csr_addr,
    input  logic [XLEN-1:0]         i_csr_wdata,
    input  logic                    i_csr_nowr,
    output logic [XLEN-1:0]         o_csr_rdata,
    output logic                    o_csr_illegal,
    input  logic                    i_instret,
    input  logic [HPM_COUNTERS-1:0] i_hpm_event,
    input  logic                    i_ext_irq,
    input  logic                    i_timer_irq,
    input  logic                    i_sw_irq,
    input  logic                    i_trap,
    input  logic [XLEN-1:0]         i_trap_cause,
    input  logic [XLEN-1:0]         i_trap_pc,
    input  logic [XLEN-1:0]         i_trap_tval,
    input  logic                    i_mret,
    output logic [XLEN-1:0]         o_mtvec,
    output logic [XLEN-1:0]         o_mepc,
    output logic                    o_irq_pending
);

    csr_op_e     csr_op;
    logic        csr_active, csr_impl, csr_would_write, csr_illegal, csr_we;
    logic [31:0] csr_rdata, csr_wval, mstatus_rd, mip_rd;

    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mcountinhibit_q, mcountinhibit_d;
    logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic        meip_q, mtip_q, msip_q;
    logic [31:0] mhpmevent_q [HPM_COUNTERS];
    logic [31:0] mhpmevent_d [HPM_COUNTERS];

    logic [63:0] mcycle_val, minstret_val;
    logic [63:0] hpm_val [HPM_COUNTERS];
    logic [HPM_COUNTERS-1:0] hpm_inc, hpm_we_lo, hpm_we_hi;

    always_comb begin
        mstatus_rd = MSTATUS_MPP_FIXED;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        mip_rd = '0;
        mip_rd[MIP_MEIP_BIT] = meip_q;
        mip_rd[MIP_MTIP_BIT] = mtip_q;
        mip_rd[MIP_MSIP_BIT] = msip_q;
    end

    // Read mux; the HPM address windows are fully legal, unpopulated slots read zero.
    always_comb begin
        csr_rdata = '0;
        csr_impl  = 1'b1;
        case (i_csr_addr)
            CSR_MSTATUS:       csr_rdata = mstatus_rd;
            CSR_MISA:          csr_rdata = MISA_VALUE;
            CSR_MIE:           csr_rdata = mie_q;
            CSR_MTVEC:         csr_rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: csr_rdata = mcountinhibit_q;
            CSR_MSCRATCH:      csr_rdata = mscratch_q;
            CSR_MEPC:          csr_rdata = mepc_q;
            CSR_MCAUSE:        csr_rdata = mcause_q;
            CSR_MTVAL:         csr_rdata = mtval_q;
            CSR_MIP:           csr_rdata = mip_rd;
            CSR_MCYCLE:        csr_rdata = mcycle_val[31:0];
            CSR_MCYCLEH:       csr_rdata = mcycle_val[63:32];
            CSR_MINSTRET:      csr_rdata = minstret_val[31:0];
            CSR_MINSTRETH:     csr_rdata = minstret_val[63:32];
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:        csr_rdata = '0;
            CSR_MHARTID:       csr_rdata = MHARTID;
            default: begin
                csr_impl = (i_csr_addr >= CSR_MHPMCOUNTER3  && i_csr_addr <= CSR_MHPMCOUNTER31)  ||
                           (i_csr_addr >= CSR_MHPMCOUNTER3H && i_csr_addr <= CSR_MHPMCOUNTER31H) ||
                           (i_csr_addr >= CSR_MHPMEVENT3    && i_csr_addr <= CSR_MHPMEVENT31);
                for (int unsigned k = 0; k < HPM_COUNTERS; k++) begin
                    if (i_csr_addr == CSR_MHPMCOUNTER3 + 12'(k))  csr_rdata = hpm_val[k][31:0];
                    if (i_csr_addr == CSR_MHPMCOUNTER3H + 12'(k)) csr_rdata = hpm_val[k][63:32];
                    if (i_csr_addr == CSR_MHPMEVENT3 + 12'(k))    csr_rdata = mhpmevent_q[k];
                end
            end
        endcase
    end

    always_comb begin
        csr_op          = csr_op_e'(i_csr_op);
        csr_active      = i_csr_valid && (csr_op != CSR_OP_NONE);
        csr_would_write = (csr_op == CSR_OP_RW) || !i_csr_nowr;
        csr_illegal     = csr_active &&
                          (!csr_impl || ((i_csr_addr[11:10] == 2'b11) && csr_would_write));
        csr_we          = csr_active && csr_would_write && !csr_illegal && !i_trap;
        csr_wval        = csr_apply_op(csr_op, csr_rdata, i_csr_wdata);
    end

    // Priority on mstatus: trap, then mret, then CSR write (csr_we already excludes trap).
    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mcountinhibit_d = mcountinhibit_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        mtval_d         = mtval_q;
        for (int unsigned k = 0; k < HPM_COUNTERS; k++) begin
            mhpmevent_d[k] = mhpmevent_q[k];
            if (csr_we && i_csr_addr == CSR_MHPMEVENT3 + 12'(k)) mhpmevent_d[k] = csr_wval;
        end

        if (i_trap) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = i_trap_pc & MEPC_WMASK;
            mcause_d       = i_trap_cause;
            mtval_d        = i_trap_tval;
        end else if (i_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we && i_csr_addr == CSR_MSTATUS) begin
            mstatus_mie_d  = csr_wval[MSTATUS_MIE_BIT];
            mstatus_mpie_d = csr_wval[MSTATUS_MPIE_BIT];
        end

        if (csr_we) begin
            case (i_csr_addr)
                CSR_MIE:           mie_d = csr_wval & MIE_WMASK;
                CSR_MTVEC:         mtvec_d = {csr_wval[31:2],
                                              csr_wval[1] ? mtvec_q[1:0] : csr_wval[1:0]};
                CSR_MCOUNTINHIBIT: mcountinhibit_d = csr_wval;
                CSR_MSCRATCH:      mscratch_d = csr_wval;
                CSR_MEPC:          mepc_d = csr_wval & MEPC_WMASK;
                CSR_MCAUSE:        mcause_d = csr_wval;
                CSR_MTVAL:         mtval_d = csr_wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= RESET_MTVEC;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            meip_q          <= 1'b0;
            mtip_q          <= 1'b0;
            msip_q          <= 1'b0;
            for (int unsigned k = 0; k < HPM_COUNTERS; k++) mhpmevent_q[k] <= '0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mcountinhibit_q <= mcountinhibit_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            mtval_q         <= mtval_d;
            meip_q          <= i_ext_irq;
            mtip_q          <= i_timer_irq;
            msip_q          <= i_sw_irq;
            for (int unsigned k = 0; k < HPM_COUNTERS; k++) mhpmevent_q[k] <= mhpmevent_d[k];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < HPM_COUNTERS; k++) begin
            hpm_inc[k]   = i_hpm_event[k] && !mcountinhibit_q[3+k];
            hpm_we_lo[k] = csr_we && (i_csr_addr == CSR_MHPMCOUNTER3 + 12'(k));
            hpm_we_hi[k] = csr_we && (i_csr_addr == CSR_MHPMCOUNTER3H + 12'(k));
        end
    end

    csr_counter64 u_mcycle (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (!mcountinhibit_q[0]),
        .i_we_lo (csr_we && i_csr_addr == CSR_MCYCLE),
        .i_we_hi (csr_we && i_csr_addr == CSR_MCYCLEH),
        .i_wdata (csr_wval),
        .o_value (mcycle_val)
    );

    csr_counter64 u_minstret (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (i_instret && !mcountinhibit_q[2]),
        .i_we_lo (csr_we && i_csr_addr == CSR_MINSTRET),
        .i_we_hi (csr_we && i_csr_addr == CSR_MINSTRETH),
        .i_wdata (csr_wval),
        .o_value (minstret_val)
    );

    for (genvar g = 0; g < HPM_COUNTERS; g++) begin : g_hpm
        csr_counter64 u_hpm (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_inc   (hpm_inc[g]),
            .i_we_lo (hpm_we_lo[g]),
            .i_we_hi (hpm_we_hi[g]),
            .i_wdata (csr_wval),
            .o_value (hpm_val[g])
        );
    end

    assign o_csr_rdata   = csr_rdata;
    assign o_csr_illegal = csr_illegal;
    assign o_mtvec       = mtvec_q;
    assign o_mepc        = mepc_q;
    assign o_irq_pending = mstatus_mie_q && |(mie_q & mip_rd);

endmodule

// File: tb/tb_csr_file_m.sv
// Directed self-checking bench for csr_file_m.
module tb_csr_file_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_nowr;
    logic [31:0] o_csr_rdata;
    logic        o_csr_illegal;
    logic        instret;
    logic [3:0]  hpm_event;
    logic        ext_irq, timer_irq, sw_irq;
    logic        trap;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret;
    logic [31:0] o_mtvec, o_mepc;
    logic        o_irq_pending;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_s;
    logic        ill_s;

    always #5 clk = ~clk;

    csr_file_m #(
        .XLEN         (32),
        .HPM_COUNTERS (4),
        .MHARTID      (32'd7),
        .RESET_MTVEC  (32'h0000_1000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_csr_valid   (csr_valid),
        .i_csr_op      (csr_op),
        .i_csr_addr    (csr_addr),
        .i_csr_wdata   (csr_wdata),
        .i_csr_nowr    (csr_nowr),
        .o_csr_rdata   (o_csr_rdata),
        .o_csr_illegal (o_csr_illegal),
        .i_instret     (instret),
        .i_hpm_event   (hpm_event),
        .i_ext_irq     (ext_irq),
        .i_timer_irq   (timer_irq),
        .i_sw_irq      (sw_irq),
        .i_trap        (trap),
        .i_trap_cause  (trap_cause),
        .i_trap_pc     (trap_pc),
        .i_trap_tval   (trap_tval),
        .i_mret        (mret),
        .o_mtvec       (o_mtvec),
        .o_mepc        (o_mepc),
        .o_irq_pending (o_irq_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CSR instruction: driven after negedge, outputs sampled 1ns later, retired at posedge.
    task automatic csr(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic nowr);
        @(negedge clk);
        csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd; csr_nowr = nowr;
        #1;
        rd_s  = o_csr_rdata;
        ill_s = o_csr_illegal;
        @(posedge clk);
        #1;
        csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0; csr_nowr = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr);
        csr(2'b10, addr, 32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
        csr_nowr = 1'b0; instret = 1'b0; hpm_event = '0; ext_irq = 1'b0; timer_irq = 1'b0;
        sw_irq = 1'b0; trap = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mtvec", o_mtvec, 32'h0000_1000);
        check("rst_mepc", o_mepc, 32'h0);
        check("rst_irq_pending", 32'(o_irq_pending), 32'h0);
        check("rst_illegal", 32'(o_csr_illegal), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // minstret counts three retire pulses, hpm1 counts two events
        instret = 1'b1;
        repeat (3) @(negedge clk);
        instret = 1'b0;
        hpm_event = 4'b0010;
        repeat (2) @(negedge clk);
        hpm_event = '0;
        rd(12'hB02); check("minstret", rd_s, 32'd3);
        rd(12'hB04); check("hpm1", rd_s, 32'd2);
        rd(12'hB03); check("hpm0", rd_s, 32'd0);

        rd(12'h300); check("mstatus_rst", rd_s, 32'h0000_1800);
        check("mstatus_rd_legal", 32'(ill_s), 32'h0);
        rd(12'hF14); check("mhartid", rd_s, 32'd7);
        rd(12'h7C0); check("unimpl_illegal", 32'(ill_s), 32'h1);

        csr(2'b01, 12'hF11, 32'd5, 1'b0); check("ro_write_illegal", 32'(ill_s), 32'h1);
        rd(12'hF11);
        check("ro_read_legal", 32'(ill_s), 32'h0);
        check("mvendorid", rd_s, 32'h0);

        rd(12'h301); check("misa", rd_s, 32'h4000_0100);
        csr(2'b01, 12'h301, 32'h0, 1'b0); check("misa_wr_legal", 32'(ill_s), 32'h0);
        rd(12'h301); check("misa_held", rd_s, 32'h4000_0100);
        csr(2'b01, 12'h344, 32'h0000_FFFF, 1'b0); check("mip_wr_legal", 32'(ill_s), 32'h0);
        rd(12'h344); check("mip_held", rd_s, 32'h0);

        // mcycle carry lo->hi
        csr(2'b01, 12'hB80, 32'h0, 1'b0);
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        rd(12'hB00); check("mcycle_lo_max", rd_s, 32'hFFFF_FFFF);
        rd(12'hB00); check("mcycle_lo_wrap", rd_s, 32'h0);
        rd(12'hB80); check("mcycle_hi_carry", rd_s, 32'h1);
        csr(2'b01, 12'hB00, 32'd100, 1'b0);
        rd(12'hB00); check("mcycle_wr_no_inc", rd_s, 32'd100);
        rd(12'hB00); check("mcycle_inc_after", rd_s, 32'd101);

        csr(2'b01, 12'h324, 32'h0000_ABCD, 1'b0);
        rd(12'h324); check("mhpmevent4", rd_s, 32'h0000_ABCD);
        csr(2'b01, 12'hB10, 32'h1234, 1'b0); check("hpm_unpop_legal", 32'(ill_s), 32'h0);
        rd(12'hB10); check("hpm_unpop_zero", rd_s, 32'h0);

        csr(2'b01, 12'h305, 32'h8000_0003, 1'b0);
        rd(12'h305); check("mtvec_mode_keep", rd_s, 32'h8000_0000);
        csr(2'b01, 12'h305, 32'h0000_0101, 1'b0);
        check("mtvec_vectored", o_mtvec, 32'h0000_0101);
        csr(2'b01, 12'h305, 32'h2000_00F2, 1'b0);
        check("mtvec_mode_keep2", o_mtvec, 32'h2000_00F1);

        csr(2'b01, 12'h304, 32'hFFFF_FFFF, 1'b0);
        rd(12'h304); check("mie_warl", rd_s, 32'h0000_0888);
        csr(2'b11, 12'h304, 32'h0000_0888, 1'b0); check("mie_rc_old", rd_s, 32'h0000_0888);
        rd(12'h304); check("mie_cleared", rd_s, 32'h0);

        // trap with a same-cycle mscratch write, which must be dropped
        csr(2'b10, 12'h300, 32'h8, 1'b0);
        rd(12'h300); check("mstatus_mie_set", rd_s, 32'h0000_1808);
        @(negedge clk);
        trap = 1'b1; trap_pc = 32'h0000_0102; trap_cause = 32'h8000_000B; trap_tval = 32'h55;
        csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234; csr_nowr = 1'b0;
        @(posedge clk);
        #1;
        trap = 1'b0; csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
        check("trap_mepc", o_mepc, 32'h0000_0100);
        rd(12'h342); check("trap_mcause", rd_s, 32'h8000_000B);
        rd(12'h343); check("trap_mtval", rd_s, 32'h55);
        rd(12'h300); check("trap_mstatus", rd_s, 32'h0000_1880);
        rd(12'h340); check("trap_drops_write", rd_s, 32'h0);

        // mret with a same-cycle mstatus write, which mret overrides
        @(negedge clk);
        mret = 1'b1;
        csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h300; csr_wdata = 32'h0; csr_nowr = 1'b0;
        @(posedge clk);
        #1;
        mret = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
        rd(12'h300); check("mret_mstatus", rd_s, 32'h0000_1888);

        csr(2'b01, 12'h304, 32'h0000_0800, 1'b0);
        @(negedge clk);
        ext_irq = 1'b1;
        #1;
        check("irq_not_yet", 32'(o_irq_pending), 32'h0);
        @(posedge clk);
        #1;
        check("irq_pending", 32'(o_irq_pending), 32'h1);
        rd(12'h344); check("mip_meip", rd_s, 32'h0000_0800);
        ext_irq = 1'b0;

        csr(2'b01, 12'h320, 32'h1, 1'b0);
        csr(2'b01, 12'hB00, 32'd500, 1'b0);
        repeat (4) @(posedge clk);
        rd(12'hB00); check("mcycle_inhibit", rd_s, 32'd500);

        // reset mid-operation beats a same-cycle write
        csr(2'b01, 12'h340, 32'h77, 1'b0);
        rd(12'h340); check("mscratch", rd_s, 32'h77);
        @(negedge clk);
        rst = 1'b1;
        csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h99;
        @(posedge clk);
        #1;
        rst = 1'b0; csr_valid = 1'b0; csr_op = 2'b00; csr_wdata = '0;
        rd(12'h340); check("rst_mscratch", rd_s, 32'h0);
        rd(12'h300); check("rst_mstatus", rd_s, 32'h0000_1800);
        rd(12'h320); check("rst_mcountinhibit", rd_s, 32'h0);
        check("rst_mtvec_again", o_mtvec, 32'h0000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
